// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register chain (DEPTH stages) with stall/flush hooks.
// Define PIPE_STAGE_REG_PERF_EN to build the saturating stall/bubble counters.
module pipe_stage_reg #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 4,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_clr_cnt,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_bubble_cnt
);

  // Slot protocol: i_valid/o_valid mark a real instruction in the slot; there is
  // no backpressure, i_stall is the only hold and i_flush turns every slot into a bubble.
  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("pipe_stage_reg: DEPTH must be in 1..4");
  end

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q [DEPTH];
  logic [CTRL_W-1:0] ctrl_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];

  // Flush clears valid/ctrl only; data is kept so flushed slots cost no data toggles.
  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < DEPTH; k++) begin
      ctrl_d[k] = ctrl_q[k];
      data_d[k] = data_q[k];
    end
    if (i_flush) begin
      valid_d = '0;
      for (int k = 0; k < DEPTH; k++) ctrl_d[k] = '0;
    end else if (!i_stall) begin
      valid_d[0] = i_valid;
      ctrl_d[0]  = i_valid ? i_ctrl : '0;
      data_d[0]  = i_data;
      for (int k = 1; k < DEPTH; k++) begin
        valid_d[k] = valid_q[k-1];
        ctrl_d[k]  = ctrl_q[k-1];
        data_d[k]  = data_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        ctrl_q[k] <= '0;
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < DEPTH; k++) begin
        ctrl_q[k] <= ctrl_d[k];
        data_q[k] <= data_d[k];
      end
    end
  end

  assign o_valid = valid_q[DEPTH-1];
  assign o_ctrl  = ctrl_q[DEPTH-1];
  assign o_data  = data_q[DEPTH-1];

`ifdef PIPE_STAGE_REG_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic             stall_inc, bubble_inc;

  assign stall_inc  = i_stall & ~i_flush;
  assign bubble_inc = ~i_stall & ~i_flush & ~i_valid;

  // Counters saturate at all-ones; clear beats a same-cycle increment.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (i_clr_cnt) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
    end else begin
      if (stall_inc && stall_cnt_q != '1)
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      if (bubble_inc && bubble_cnt_q != '1)
        bubble_cnt_d = bubble_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign o_stall_cnt  = stall_cnt_q;
  assign o_bubble_cnt = bubble_cnt_q;
`else
  logic unused_clr;
  assign unused_clr   = i_clr_cnt;
  assign o_stall_cnt  = '0;
  assign o_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: DEPTH=1 and DEPTH=3 instances share one stimulus stream.
module tb_pipe_stage_reg;

  localparam int DW = 32;
  localparam int CW = 4;
  localparam int NW = 4;
  localparam int CNT_MAX = (1 << NW) - 1;

  typedef struct packed {
    logic          v;
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } slot_t;

  typedef struct packed {
    logic          v;
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    logic [NW-1:0] sc;
    logic [NW-1:0] bc;
  } exp_t;

  localparam int EW = $bits(exp_t);

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          i_valid, i_stall, i_flush, i_clr_cnt;
  logic [CW-1:0] i_ctrl;
  logic [DW-1:0] i_data;

  logic          o_valid1, o_valid3;
  logic [CW-1:0] o_ctrl1, o_ctrl3;
  logic [DW-1:0] o_data1, o_data3;
  logic [NW-1:0] o_sc1, o_sc3, o_bc1, o_bc3;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(1), .CNT_W(NW)) u_dut1 (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_ctrl(i_ctrl), .i_data(i_data),
    .i_stall(i_stall), .i_flush(i_flush), .i_clr_cnt(i_clr_cnt),
    .o_valid(o_valid1), .o_ctrl(o_ctrl1), .o_data(o_data1),
    .o_stall_cnt(o_sc1), .o_bubble_cnt(o_bc1)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(3), .CNT_W(NW)) u_dut3 (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_ctrl(i_ctrl), .i_data(i_data),
    .i_stall(i_stall), .i_flush(i_flush), .i_clr_cnt(i_clr_cnt),
    .o_valid(o_valid3), .o_ctrl(o_ctrl3), .o_data(o_data3),
    .o_stall_cnt(o_sc3), .o_bubble_cnt(o_bc3)
  );

  // ---------------- reference model ----------------
  // Index 0 models the DEPTH=1 instance, index 1 the DEPTH=3 instance.
  slot_t         mq[2][$];
  logic [EW-1:0] exp_q[2][$];
  int            sc, bc;
  int            n_checks = 0;
  int            n_fail = 0;
  logic          prev_rst = 1'b0;

  function automatic int depth_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic model_reset();
    slot_t z;
    z = '0;
    sc = 0;
    bc = 0;
    for (int k = 0; k < 2; k++) begin
      mq[k] = {};
      for (int j = 0; j < depth_of(k); j++) mq[k].push_back(z);
    end
  endtask

  task automatic model_edge(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                            input logic st, input logic fl, input logic clr);
    slot_t s;
    if (clr) begin
      sc = 0;
      bc = 0;
    end else begin
      if (st && !fl && sc < CNT_MAX) sc++;
      if (!st && !fl && !v && bc < CNT_MAX) bc++;
    end
    s.v = v;
    s.c = v ? c : '0;
    s.d = d;
    for (int k = 0; k < 2; k++) begin
      if (fl) begin
        for (int j = 0; j < mq[k].size(); j++) begin
          mq[k][j].v = 1'b0;
          mq[k][j].c = '0;
        end
      end else if (!st) begin
        mq[k].push_front(s);
        void'(mq[k].pop_back());
      end
    end
  endtask

  task automatic push_expected();
    exp_t  e;
    slot_t last;
    for (int k = 0; k < 2; k++) begin
      last = mq[k][mq[k].size()-1];
      e.v = last.v;
      e.c = last.c;
      e.d = last.d;
`ifdef PIPE_STAGE_REG_PERF_EN
      e.sc = NW'(sc);
      e.bc = NW'(bc);
`else
      e.sc = '0;
      e.bc = '0;
`endif
      exp_q[k].push_back(e);
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid1"}, 64'(o_valid1), 64'h0);
    check({tag, "_ctrl1"},  64'(o_ctrl1),  64'h0);
    check({tag, "_data1"},  64'(o_data1),  64'h0);
    check({tag, "_valid3"}, 64'(o_valid3), 64'h0);
    check({tag, "_ctrl3"},  64'(o_ctrl3),  64'h0);
    check({tag, "_data3"},  64'(o_data3),  64'h0);
    check({tag, "_cnt3"},   64'({o_sc3, o_bc3}), 64'h0);
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic rst, input logic v, input logic [CW-1:0] c,
                      input logic [DW-1:0] d, input logic st, input logic fl, input logic clr);
    @(negedge clk);
    reset     = rst;
    i_valid   = v;
    i_ctrl    = c;
    i_data    = d;
    i_stall   = st;
    i_flush   = fl;
    i_clr_cnt = clr;
    if (rst) begin
      model_reset();
      if (!prev_rst) begin
        #1;
        check_all_zero("async_rst");
      end
    end else begin
      model_edge(v, c, d, st, fl, clr);
    end
    push_expected();
    prev_rst = rst;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, $urandom, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (exp_q[k].size() > 0) begin
          e = exp_t'(exp_q[k].pop_front());
          if (k == 0) begin
            check("d1_valid", 64'(o_valid1), 64'(e.v));
            check("d1_ctrl",  64'(o_ctrl1),  64'(e.c));
            check("d1_data",  64'(o_data1),  64'(e.d));
            check("d1_cnts",  64'({o_sc1, o_bc1}), 64'({e.sc, e.bc}));
          end else begin
            check("d3_valid", 64'(o_valid3), 64'(e.v));
            check("d3_ctrl",  64'(o_ctrl3),  64'(e.c));
            check("d3_data",  64'(o_data3),  64'(e.d));
            check("d3_cnts",  64'({o_sc3, o_bc3}), 64'({e.sc, e.bc}));
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    reset = 1'b1;
    i_valid = 1'b0;
    i_ctrl = '0;
    i_data = '0;
    i_stall = 1'b0;
    i_flush = 1'b0;
    i_clr_cnt = 1'b0;
    model_reset();
    #1;
    check_all_zero("reset");
    prev_rst = 1'b1;
    step(1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    // single token, visible after 1 / 3 edges
    step(1'b0, 1'b1, 4'hA, 32'h1234, 1'b0, 1'b0, 1'b0);
    idle(4);

    // stall one cycle while the token is in flight
    step(1'b0, 1'b1, 4'h5, 32'hBEEF, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'h0, 32'h1111, 1'b1, 1'b0, 1'b0);
    idle(4);

    // flush together with stall while valid data is in flight
    step(1'b0, 1'b1, 4'h3, 32'hA0A0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'h7, 32'hB1B1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'h9, 32'hC2C2, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'hE, 32'hD3D3, 1'b1, 1'b1, 1'b0);
    idle(2);

    // invalid slot with nonzero ctrl: ctrl dropped, data still carried
    step(1'b0, 1'b0, 4'hF, 32'h5555, 1'b0, 1'b0, 1'b0);
    idle(3);

    // reset between edges while o_valid=1
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'h6, 32'h7000 + i, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'h6, 32'h7777, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'h2, 32'h8888, 1'b0, 1'b0, 1'b0);

    // counter saturation and clear-with-stall
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    idle(20);
    step(1'b0, 1'b1, 4'h1, 32'h4242, 1'b0, 1'b0, 1'b1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 65, 4'($urandom), $urandom,
           $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 8,
           $urandom_range(0, 99) < 5);
    end
    idle(4);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && (exp_q[0].size() != 0 || exp_q[1].size() != 0); i++)
      @(negedge clk);
    check("drain", 64'(exp_q[0].size() + exp_q[1].size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
